// File: rtl/dmem_ctrl.sv
// Byte/halfword/word data memory with a valid/ready request port, alignment and range
// checking, and a fixed-latency registered response.
module dmem_ctrl #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic [31:0]        pend_rdata_q;
    logic               pend_err_q;
    logic [31:0]        mem_q [DEPTH];

    logic               accept_c;
    logic [IDX_W-1:0]   widx_c;
    logic [MIDX_W-1:0]  midx_c;
    logic [1:0]         lane_c;
    logic               range_err_c;
    logic               err_c;
    logic [31:0]        word_c;
    logic [31:0]        shifted_c;
    logic [31:0]        ext_c;
    logic [31:0]        rdata_c;
    logic [3:0]         wmask_c;
    logic [31:0]        wdata_c;

    assign accept_c  = req_valid && ready_q;
    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Request decode: error detection, load extraction and store lane alignment
    always_comb begin
        widx_c      = req_addr[ADDR_W-1:2];
        midx_c      = MIDX_W'(widx_c);
        lane_c      = req_addr[1:0];
        range_err_c = 64'(widx_c) >= 64'(DEPTH);
        err_c       = range_err_c
                    || (req_size == 2'b11)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (lane_c != 2'b00));
        word_c      = range_err_c ? 32'h0 : mem_q[midx_c];
        shifted_c   = word_c >> {lane_c, 3'b000};
        ext_c       = word_c;
        wmask_c     = 4'b1111;
        wdata_c     = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                ext_c   = req_unsigned ? {24'h0, shifted_c[7:0]}
                                       : {{24{shifted_c[7]}}, shifted_c[7:0]};
                wmask_c = 4'b0001 << lane_c;
                wdata_c = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                ext_c   = req_unsigned ? {16'h0, shifted_c[15:0]}
                                       : {{16{shifted_c[15]}}, shifted_c[15:0]};
                wmask_c = lane_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                ext_c   = word_c;
                wmask_c = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
        rdata_c = (req_we || err_c) ? 32'h0 : ext_c;
    end

    // Storage is deliberately not reset; stores commit on their accept edge
    always_ff @(posedge clk) begin
        if (rst_n && accept_c && req_we && !err_c) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask_c[k]) begin
                    mem_q[midx_c][8*k +: 8] <= wdata_c[8*k +: 8];
                end
            end
        end
    end

    // Handshake FSM with latency down-counter; response fields load as rsp_valid rises
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
            pend_rdata_q <= 32'h0;
            pend_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (accept_c) begin
                        state_q      <= WAIT;
                        ready_q      <= 1'b0;
                        cnt_q        <= CNT_INIT;
                        pend_rdata_q <= rdata_c;
                        pend_err_q   <= err_c;
                        if (CNT_INIT == '0) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_c;
                            rsp_err_q   <= err_c;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= pend_rdata_q;
                            rsp_err_q   <= pend_err_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: LATENCY=1 and LATENCY=3 instances share request inputs,
// expected responses are queued at accept and compared when rsp_valid fires.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 64;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        valid1, valid3;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready1, ready3;
    logic        rv1, rv3;
    logic [31:0] rd1, rd3;
    logic        re1, re3;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
    );

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic o_ready(input int d);
        return (d == 1) ? ready1 : ready3;
    endfunction
    function automatic logic o_rv(input int d);
        return (d == 1) ? rv1 : rv3;
    endfunction
    function automatic logic [31:0] o_rd(input int d);
        return (d == 1) ? rd1 : rd3;
    endfunction
    function automatic logic o_re(input int d);
        return (d == 1) ? re1 : re3;
    endfunction

    task automatic set_valid(input int d, input logic v);
        if (d == 1) valid1 = v;
        else        valid3 = v;
    endtask

    // One request on instance d; inputs are scrambled while the response is pending
    task automatic do_req(input int d, input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int   cyc;
        bit   seen;
        exp_t e;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        set_valid(d, 1'b1);
        cyc = 0;
        while (!o_ready(d) && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " ready_before"}, 32'(o_ready(d)), 32'd1);
        @(posedge clk);
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        #1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_addr     = 32'h20;
        req_wdata    = $urandom;
        req_unsigned = 1'($urandom);
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 8) begin
            if (o_rv(d)) begin
                seen = 1'b1;
                break;
            end
            chk({tag, " ready_wait"}, 32'(o_ready(d)), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        set_valid(d, 1'b0);
        chk({tag, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, (d == 1) ? 32'd1 : 32'd3);
        e = sb_q.pop_front();
        chk({tag, " rdata"}, o_rd(d), e.rdata);
        chk({tag, " err"}, 32'(o_re(d)), 32'(e.err));
        chk({tag, " ready_rsp"}, 32'(o_ready(d)), 32'd0);
        @(posedge clk); #1;
        chk({tag, " ready_after"}, 32'(o_ready(d)), 32'd1);
        chk({tag, " pulse"}, 32'(o_rv(d)), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " ready1"}, 32'(ready1), 32'd1);
        chk({tag, " rv1"}, 32'(rv1), 32'd0);
        chk({tag, " rd1"}, rd1, 32'h0);
        chk({tag, " re1"}, 32'(re1), 32'd0);
        chk({tag, " ready3"}, 32'(ready3), 32'd1);
        chk({tag, " rv3"}, 32'(rv3), 32'd0);
    endtask

    initial begin
        bit rsp_seen;
        rst_n        = 1'b0;
        valid1       = 1'b1;
        valid3       = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h40;
        req_wdata    = 32'hBAD0_BAD0;

        // Reset held two cycles with a request present
        @(posedge clk); @(posedge clk); #1;
        rst_n  = 1'b1;
        valid1 = 1'b0;
        valid3 = 1'b0;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        // Word store/load, LATENCY=1
        do_req(1, "st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_req(1, "ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte and halfword merge
        do_req(1, "st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0000, 32'h0, 1'b0);
        do_req(1, "st_b23", 1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_0085, 32'h0, 1'b0);
        do_req(1, "st_h20", 1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_1234, 32'h0, 1'b0);
        do_req(1, "ld_w20", 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h8500_1234, 1'b0);
        do_req(1, "ld_sb23", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFF_FF85, 1'b0);
        do_req(1, "ld_ub23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h0000_0085, 1'b0);
        do_req(1, "ld_sh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF_8500, 1'b0);
        do_req(1, "ld_uh20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_1234, 1'b0);

        // Rejected accesses (stores, so a write would show up on re-read)
        do_req(1, "err_h21", 1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req(1, "err_w22", 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req(1, "err_sz3", 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req(1, "err_rng", 1'b1, 2'b10, 1'b0, 32'(4 * DEPTH), 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req(1, "err_ldrng", 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        do_req(1, "reread_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h8500_1234, 1'b0);

        // Request during reset must not be accepted
        do_req(1, "st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0102_0304, 32'h0, 1'b0);
        rst_n     = 1'b0;
        valid1    = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h30;
        req_wdata = 32'hBAD0_BAD0;
        @(posedge clk); @(posedge clk); #1;
        rst_n  = 1'b1;
        valid1 = 1'b0;
        do_req(1, "ld_w30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0102_0304, 1'b0);

        // LATENCY=3 with inputs toggled during WAIT
        do_req(3, "l3_st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1357_9BDF, 32'h0, 1'b0);
        do_req(3, "l3_ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1357_9BDF, 1'b0);
        do_req(3, "l3_ld_sb21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFF_FF9B, 1'b0);
        do_req(3, "l3_err_w22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);

        // Reset one cycle after accepting a store drops the response, keeps the data
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h08;
        req_wdata    = 32'hCAFE_F00D;
        valid3       = 1'b1;
        chk("midrst ready", 32'(ready3), 32'd1);
        @(posedge clk); #1;
        valid3 = 1'b0;
        rst_n  = 1'b0;
        rsp_seen = 1'b0;
        @(posedge clk); #1;
        rsp_seen |= rv3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rsp_seen |= rv3;
        end
        chk("midrst no_rsp", 32'(rsp_seen), 32'd0);
        chk("midrst ready_after", 32'(ready3), 32'd1);
        do_req(3, "midrst_ld_w08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hCAFE_F00D, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised successor to the single-cycle 32-bit data memory. It adds byte, halfword and word loads and stores with sign or zero extension, and detects misaligned and out-of-range accesses. Requests use a valid/ready handshake, and responses arrive after a configurable fixed latency. It sits between the pipelined CPU's MEM stage and a word-organised storage array, replacing the combinational-read memory.

## Interface
- DEPTH, 64: storage size in 32-bit words; any value ≥ 1.
- ADDR_W, 32: width of the byte address.
- LATENCY, 1: cycles from the accept edge to `rsp_valid`; legal range 1..4.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (the byte is in [7:0], the halfword in [15:0]).
- rsp_valid  output  1  one-cycle pulse; response fields are valid.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  access rejected (misaligned, out of range, or illegal size).

## Operation
**Handshake and states**
- A request is accepted on a rising edge where `req_valid && req_ready`.
- State machine: IDLE → WAIT → IDLE.
- `req_ready` = 1 only in IDLE.
- On accept, the FSM goes to WAIT and loads a down-counter with LATENCY-1.
- WAIT with counter = 0: assert `rsp_valid` for that cycle, then return to IDLE.
- WAIT with counter ≠ 0: decrement the counter.
- There is no response back-pressure; the consumer must take `rsp_valid` when it fires.

**Addressing**
- Word index = `req_addr[ADDR_W-1:2]`.
- Byte lane = `req_addr[1:0]`, little-endian: lane k = bits [8k+7:8k].

**Error checks** (evaluated at the accept edge)
- Halfword with `addr[0]` = 1.
- Word with `addr[1:0]` ≠ 0.
- `req_size` = 11.
- Word index ≥ DEPTH.
- On any error: no write occurs, `rsp_err` = 1, `rsp_rdata` = 0.

**Stores** (commit at the accept edge)
- Byte store: writes `wdata[7:0]` into lane `addr[1:0]`.
- Halfword store: writes `wdata[15:0]` into lanes {2·addr[1]+1, 2·addr[1]}.
- Word store: writes all four lanes.
- Lanes not written keep their contents.

**Loads**
- The addressed word is sampled at the accept edge.
- The selected lane(s) are extracted, then sign- or zero-extended per `req_unsigned` and registered.
- For word loads, `req_unsigned` is ignored.

**Storage and ordering**
- Storage contents are not reset.
- A load accepted after a store returns the stored data, because the store committed at its own accept edge.

**Reset**
- With `rst_n` = 0 at an edge: state = IDLE, counter = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- `req_ready` is 1 from the first cycle after reset.
- Reset in WAIT drops the pending response; a store accepted before the reset stays committed.
- A request presented in the same cycle as active reset is not accepted.

## Timing
- Accept at edge N → `rsp_valid` high during the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- `req_ready` is low from edge N until the edge that ends the `rsp_valid` cycle.
- The next accept can happen one cycle after the response, giving a peak throughput of 1 request per LATENCY+1 cycles.
- `rsp_rdata` and `rsp_err` are registered and held until the next response or reset; they are only meaningful while `rsp_valid` = 1.
- `req_*` inputs are sampled only at the accept edge; changes while `req_ready` = 0 are ignored.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with `req_valid` = 1 → no accept. After release: `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- **Word store/load, LATENCY = 1:** store word 0xDEADBEEF @ 0x10, then load word @ 0x10 → `rsp_valid` exactly 1 cycle after each accept; load returns 0xDEADBEEF, `rsp_err` = 0; `req_ready` is low for 1 cycle per request.
- **Byte and halfword merge:** word 0x00000000 @ 0x20, then store byte 0x85 @ 0x23 and halfword 0x1234 @ 0x20.
  - Load word @ 0x20 → 0x85001234.
  - Signed byte load @ 0x23 → 0xFFFFFF85.
  - Unsigned byte load @ 0x23 → 0x00000085.
  - Signed halfword load @ 0x22 → 0xFFFF8500.
- **Errors:** each access below → `rsp_err` = 1, `rsp_rdata` = 0, and word @ 0x20 unchanged on re-read:
  - halfword @ 0x21;
  - word @ 0x22;
  - size 11;
  - word @ 4·DEPTH.
- **LATENCY = 3:** load accepted at edge N → `rsp_valid` only in the cycle after edge N+2. Inputs toggled during WAIT do not affect the result, and `req_ready` returns high on the following cycle.
- **Reset mid-operation, LATENCY = 3:** accept a store of 0xCAFEF00D @ 0x08, assert `rst_n` = 0 one cycle later → no `rsp_valid` is produced. A load @ 0x08 after reset returns 0xCAFEF00D.
